// File: rtl/digest_squeeze.sv
// digest_squeeze: streams the first 4..8 lanes of a post-permutation Keccak
// state as 64-bit words with valid/ready handshaking, byte enables for the
// truncated SHA3-224 tail, a last-word flag and a one-cycle done pulse.
module digest_squeeze (
  input  logic          clk,
  input  logic          rst,
  input  logic [1599:0] sqz_in_state,
  input  logic [1:0]    sqz_mode,
  input  logic          sqz_start,
  input  logic          sqz_out_ready,
  output logic          sqz_busy,
  output logic [63:0]   sqz_out_word,
  output logic          sqz_out_valid,
  output logic          sqz_out_last,
  output logic [7:0]    sqz_out_keep,
  output logic          sqz_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      r_state;
  logic [63:0] r_lane [0:7];
  logic [1:0]  r_mode;
  logic [2:0]  r_idx;
  logic        r_busy;
  logic [63:0] r_out_word;
  logic        r_out_valid;
  logic        r_out_last;
  logic [7:0]  r_out_keep;
  logic        r_done;

  logic [63:0] w_in_lane [0:7];
  logic [2:0]  w_last_idx;
  logic [2:0]  w_next_idx;
  logic        w_next_last;
  logic [63:0] w_next_word;
  logic [7:0]  w_next_keep;
  logic        w_unused_upper;

  // Only lanes 0..7 can ever form a digest; the rest of the state is dropped.
  assign w_unused_upper = ^sqz_in_state[1599:512];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_lane
      assign w_in_lane[gi] = sqz_in_state[64*gi +: 64];
    end
  endgenerate

  // Index of the final word for the captured digest length.
  always_comb begin
    w_last_idx = 3'd3;
    case (r_mode)
      2'b00:   w_last_idx = 3'd7;
      2'b01:   w_last_idx = 3'd5;
      default: w_last_idx = 3'd3;
    endcase
  end

  // Presentation of the word that follows the current one, so outputs stay registered.
  always_comb begin
    w_next_idx  = r_idx + 3'd1;
    w_next_last = (w_next_idx == w_last_idx);
    w_next_word = r_lane[w_next_idx];
    w_next_keep = 8'hFF;
    if (w_next_last && (r_mode == 2'b10)) begin
      // SHA3-224 ends half-way through its fourth lane.
      w_next_word = {32'h0, r_lane[w_next_idx][31:0]};
      w_next_keep = 8'h0F;
    end
  end

  // Control FSM: capture in IDLE, stream in SEND, pulse done in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= 2'b00;
      r_idx       <= 3'd0;
      r_busy      <= 1'b0;
      r_out_word  <= 64'h0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_keep  <= 8'h00;
      r_done      <= 1'b0;
      for (int i = 0; i < 8; i++) r_lane[i] <= 64'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (sqz_start) begin
            for (int i = 0; i < 8; i++) r_lane[i] <= w_in_lane[i];
            r_mode      <= sqz_mode;
            r_idx       <= 3'd0;
            r_state     <= SEND;
            r_busy      <= 1'b1;
            // Word 0 is never the last word, so it is always a full lane.
            r_out_word  <= w_in_lane[0];
            r_out_valid <= 1'b1;
            r_out_keep  <= 8'hFF;
            r_out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (sqz_out_ready) begin
            if (r_idx == w_last_idx) begin
              r_state     <= DONE;
              r_out_word  <= 64'h0;
              r_out_valid <= 1'b0;
              r_out_keep  <= 8'h00;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_idx       <= w_next_idx;
              r_out_word  <= w_next_word;
              r_out_keep  <= w_next_keep;
              r_out_last  <= w_next_last;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sqz_busy      = r_busy;
  assign sqz_out_word  = r_out_word;
  assign sqz_out_valid = r_out_valid;
  assign sqz_out_last  = r_out_last;
  assign sqz_out_keep  = r_out_keep;
  assign sqz_done      = r_done;

endmodule

// File: tb/tb_digest_squeeze.sv
// Directed bench for digest_squeeze: each task drives one scenario and checks inline.
module tb_digest_squeeze;

  logic          clk;
  logic          rst;
  logic [1599:0] sqz_in_state;
  logic [1:0]    sqz_mode;
  logic          sqz_start;
  logic          sqz_out_ready;
  logic          sqz_busy;
  logic [63:0]   sqz_out_word;
  logic          sqz_out_valid;
  logic          sqz_out_last;
  logic [7:0]    sqz_out_keep;
  logic          sqz_done;

  integer checks;
  integer errors;

  digest_squeeze dut (
    .clk          (clk),
    .rst          (rst),
    .sqz_in_state (sqz_in_state),
    .sqz_mode     (sqz_mode),
    .sqz_start    (sqz_start),
    .sqz_out_ready(sqz_out_ready),
    .sqz_busy     (sqz_busy),
    .sqz_out_word (sqz_out_word),
    .sqz_out_valid(sqz_out_valid),
    .sqz_out_last (sqz_out_last),
    .sqz_out_keep (sqz_out_keep),
    .sqz_done     (sqz_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    sqz_start = 1'b0;
    sqz_out_ready = 1'b1;
    while (sqz_busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (sqz_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout busy=%b required 0", sqz_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sqz_start = 1'b0; sqz_out_ready = 1'b0;
    sqz_mode = 2'b00; sqz_in_state = '0;
    step(); step();
    checks++;
    if (sqz_busy !== 1'b0 || sqz_out_valid !== 1'b0 || sqz_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b valid=%b done=%b required 0 0 0", sqz_busy, sqz_out_valid, sqz_done);
    end
    checks++;
    if (sqz_out_word !== 64'h0 || sqz_out_keep !== 8'h00 || sqz_out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_data word=%h keep=%h last=%b required 0 00 0", sqz_out_word, sqz_out_keep, sqz_out_last);
    end
    rst = 1'b0;
    step();
    checks++;
    if (sqz_busy !== 1'b0 || sqz_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b valid=%b required 0 0", sqz_busy, sqz_out_valid);
    end
  endtask

  // SHA3-256, ready high: four lanes with no bubbles, done on the cycle after.
  task automatic test_sha256();
    logic [63:0] exp_w [0:3];
    exp_w[0] = 64'h1111_1111_1111_1111; exp_w[1] = 64'h2222_2222_2222_2222;
    exp_w[2] = 64'h3333_3333_3333_3333; exp_w[3] = 64'h4444_4444_4444_4444;
    sqz_in_state = '0;
    for (int k = 0; k < 8; k++) sqz_in_state[64*k +: 64] = 64'h1111_1111_1111_1111 * (k + 1);
    sqz_mode = 2'b11; sqz_out_ready = 1'b1; sqz_start = 1'b1;
    step();
    sqz_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      $display("sha256 word %0d = %h keep=%h last=%b", k, sqz_out_word, sqz_out_keep, sqz_out_last);
      checks++;
      if (sqz_out_valid !== 1'b1 || sqz_busy !== 1'b1 || sqz_out_word !== exp_w[k] ||
          sqz_out_keep !== 8'hFF || sqz_out_last !== (k == 3 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL sha256_word%0d valid=%b busy=%b word=%h keep=%h last=%b required 1 1 %h FF %b",
                 k, sqz_out_valid, sqz_busy, sqz_out_word, sqz_out_keep, sqz_out_last,
                 exp_w[k], (k == 3 ? 1'b1 : 1'b0));
      end
      step();
    end
    checks++;
    if (sqz_done !== 1'b1 || sqz_out_valid !== 1'b0 || sqz_busy !== 1'b1 || sqz_out_word !== 64'h0) begin
      errors++;
      $display("FAIL sha256_done done=%b valid=%b busy=%b word=%h required 1 0 1 0",
               sqz_done, sqz_out_valid, sqz_busy, sqz_out_word);
    end
    step();
    checks++;
    if (sqz_done !== 1'b0 || sqz_busy !== 1'b0) begin
      errors++;
      $display("FAIL sha256_idle done=%b busy=%b required 0 0", sqz_done, sqz_busy);
    end
  endtask

  // SHA3-224: last word truncated to 32 bits with keep 0F.
  task automatic test_sha224();
    logic [63:0] exp_w [0:3];
    logic [7:0]  exp_k [0:3];
    exp_w[0] = 64'h0102_0304_0506_0708; exp_w[1] = 64'hA5A5_5A5A_F0F0_0F0F;
    exp_w[2] = 64'h7777_8888_9999_AAAA; exp_w[3] = 64'h0000_0000_CAFE_F00D;
    exp_k[0] = 8'hFF; exp_k[1] = 8'hFF; exp_k[2] = 8'hFF; exp_k[3] = 8'h0F;
    sqz_in_state = '1;
    sqz_in_state[63:0]    = 64'h0102_0304_0506_0708;
    sqz_in_state[127:64]  = 64'hA5A5_5A5A_F0F0_0F0F;
    sqz_in_state[191:128] = 64'h7777_8888_9999_AAAA;
    sqz_in_state[255:192] = 64'hDEAD_BEEF_CAFE_F00D;
    sqz_mode = 2'b10; sqz_out_ready = 1'b1; sqz_start = 1'b1;
    step();
    sqz_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      $display("sha224 word %0d = %h keep=%h last=%b", k, sqz_out_word, sqz_out_keep, sqz_out_last);
      checks++;
      if (sqz_out_valid !== 1'b1 || sqz_out_word !== exp_w[k] || sqz_out_keep !== exp_k[k] ||
          sqz_out_last !== (k == 3 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL sha224_word%0d valid=%b word=%h keep=%h last=%b required 1 %h %h %b",
                 k, sqz_out_valid, sqz_out_word, sqz_out_keep, sqz_out_last,
                 exp_w[k], exp_k[k], (k == 3 ? 1'b1 : 1'b0));
      end
      step();
    end
    checks++;
    if (sqz_done !== 1'b1) begin
      errors++;
      $display("FAIL sha224_done done=%b required 1", sqz_done);
    end
    drain();
  endtask

  // SHA3-512 with ready pattern 1,0,0 repeating: outputs hold during stalls.
  task automatic test_stall();
    logic [63:0] lanes [0:7];
    int n, cyc, pulses;
    for (int k = 0; k < 8; k++) lanes[k] = {32'hC0DE_0000 + k, 32'h0000_F000 + 3 * k};
    sqz_in_state = '0;
    for (int k = 0; k < 8; k++) sqz_in_state[64*k +: 64] = lanes[k];
    sqz_mode = 2'b00; sqz_out_ready = 1'b1; sqz_start = 1'b1;
    step();
    sqz_start = 1'b0;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 200) begin
      sqz_out_ready = (cyc % 3 == 0);
      checks++;
      if (sqz_out_valid !== 1'b1 || sqz_out_word !== lanes[n] || sqz_out_keep !== 8'hFF ||
          sqz_out_last !== (n == 7 ? 1'b1 : 1'b0) || sqz_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_cyc%0d valid=%b word=%h keep=%h last=%b done=%b required 1 %h FF %b 0",
                 cyc, sqz_out_valid, sqz_out_word, sqz_out_keep, sqz_out_last, sqz_done,
                 lanes[n], (n == 7 ? 1'b1 : 1'b0));
      end
      if (sqz_out_ready) $display("sha512 word %0d = %h", n, sqz_out_word);
      step();
      if (sqz_out_ready) n++;
      cyc++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL stall_count transfers=%0d required 8", n);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (sqz_done === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL stall_done_pulses got=%0d required 1", pulses);
    end
    drain();
  endtask

  // SHA3-384 with inputs disturbed and start re-pulsed mid-digest.
  task automatic test_ignore();
    logic [63:0] lanes [0:7];
    int n;
    for (int k = 0; k < 8; k++) lanes[k] = 64'h3840_0000_0000_0000 + 64'(k * 17);
    sqz_in_state = '0;
    for (int k = 0; k < 8; k++) sqz_in_state[64*k +: 64] = lanes[k];
    sqz_mode = 2'b01; sqz_out_ready = 1'b1; sqz_start = 1'b1;
    step();
    sqz_start = 1'b0;
    n = 0;
    for (int c = 0; c < 12 && sqz_out_valid === 1'b1; c++) begin
      checks++;
      if (sqz_out_word !== lanes[n] || sqz_out_keep !== 8'hFF || sqz_out_last !== (n == 5 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL ignore_word%0d word=%h keep=%h last=%b required %h FF %b",
                 n, sqz_out_word, sqz_out_keep, sqz_out_last, lanes[n], (n == 5 ? 1'b1 : 1'b0));
      end
      if (c == 1) begin
        sqz_in_state = {25{64'hBAD0_BAD0_BAD0_BAD0}};
        sqz_mode = 2'b00;
        sqz_start = 1'b1;
      end else begin
        sqz_start = 1'b0;
      end
      step();
      n++;
    end
    checks++;
    if (n != 6 || sqz_done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_count words=%0d done=%b required 6 1", n, sqz_done);
    end
    drain();
  endtask

  // Reset in the middle of a SHA3-512 digest, then a fresh capture.
  task automatic test_reset_mid();
    sqz_in_state = '0;
    for (int k = 0; k < 8; k++) sqz_in_state[64*k +: 64] = 64'hA000_0000_0000_0000 + 64'(k);
    sqz_mode = 2'b00; sqz_out_ready = 1'b1; sqz_start = 1'b1;
    step();
    sqz_start = 1'b0;
    step(); step();
    checks++;
    if (sqz_out_word !== 64'hA000_0000_0000_0002) begin
      errors++;
      $display("FAIL rstmid_pre word=%h required a000000000000002", sqz_out_word);
    end
    rst = 1'b1; sqz_start = 1'b1;
    step();
    rst = 1'b0; sqz_start = 1'b0;
    checks++;
    if (sqz_out_valid !== 1'b0 || sqz_busy !== 1'b0 || sqz_done !== 1'b0 || sqz_out_word !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_after valid=%b busy=%b done=%b word=%h required 0 0 0 0",
               sqz_out_valid, sqz_busy, sqz_done, sqz_out_word);
    end
    step();
    checks++;
    if (sqz_done !== 1'b0 || sqz_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nodone done=%b busy=%b required 0 0", sqz_done, sqz_busy);
    end
    for (int k = 0; k < 8; k++) sqz_in_state[64*k +: 64] = 64'h5555_0000_0000_0000 + 64'(k);
    sqz_start = 1'b1;
    step();
    sqz_start = 1'b0;
    checks++;
    if (sqz_out_valid !== 1'b1 || sqz_out_word !== 64'h5555_0000_0000_0000) begin
      errors++;
      $display("FAIL rstmid_restart valid=%b word=%h required 1 5555000000000000", sqz_out_valid, sqz_out_word);
    end
    drain();
  endtask

  // Start held high: SEND x4, DONE, one IDLE capture cycle, repeat.
  task automatic test_back_to_back();
    sqz_in_state = '0;
    for (int k = 0; k < 8; k++) sqz_in_state[64*k +: 64] = 64'h1111_1111_1111_1111 * (k + 1);
    sqz_mode = 2'b11; sqz_out_ready = 1'b1; sqz_start = 1'b1;
    step();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (sqz_busy !== 1'b1 || sqz_out_valid !== 1'b1 ||
            sqz_out_word !== 64'h1111_1111_1111_1111 * (k + 1)) begin
          errors++;
          $display("FAIL b2b_r%0d_w%0d busy=%b valid=%b word=%h", r, k, sqz_busy, sqz_out_valid, sqz_out_word);
        end
        step();
      end
      checks++;
      if (sqz_busy !== 1'b1 || sqz_done !== 1'b1 || sqz_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_r%0d_done busy=%b done=%b valid=%b required 1 1 0", r, sqz_busy, sqz_done, sqz_out_valid);
      end
      step();
      checks++;
      if (sqz_busy !== 1'b0 || sqz_out_valid !== 1'b0 || sqz_done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_r%0d_idle busy=%b valid=%b done=%b required 0 0 0", r, sqz_busy, sqz_out_valid, sqz_done);
      end
      step();
    end
    checks++;
    if (sqz_busy !== 1'b1 || sqz_out_word !== 64'h1111_1111_1111_1111) begin
      errors++;
      $display("FAIL b2b_third busy=%b word=%h required 1 1111111111111111", sqz_busy, sqz_out_word);
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sha256();
    test_sha224();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
